fp_mul_pipe: RTL and testbench
==============================

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored mantissa field width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand pair present.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-007 SHALL have ports a and b, input, W bits each: IEEE-754 style operands.
REQ-008 SHALL have port out_valid, output, 1 bit: result present.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-010 SHALL have port result, output, W bits: product.
REQ-011 SHALL have port flags, output, 4 bits: {invalid, overflow, underflow, inexact} for the presented result.

Function
REQ-012 SHALL be a 3-stage pipeline: S1 unpack/classify/multiply, S2 normalise/exponent, S3 round/pack; latency exactly 3 cycles from accepted input to out_valid with no stall.
REQ-013 SHALL use global stall: advance = !out_valid || out_ready; in_ready = advance; a transfer occurs on in_valid && in_ready.
REQ-014 SHALL hold result, flags and out_valid stable while out_valid && !out_ready.
REQ-015 SHALL propagate bubbles: a stage holding no valid data carries valid=0; throughput is 1 result per cycle when out_ready stays high.
REQ-016 SHALL compute sign = a.sign XOR b.sign for every case, including zero, infinity and overflow results.
REQ-017 SHALL form the (MAN_W+1)x(MAN_W+1) mantissa product with hidden bits and a biased exponent sum minus bias (2^(EXP_W-1)-1) in EXP_W+2 signed bits.
REQ-018 SHALL normalise by a 1-bit right shift plus exponent+1 when the product MSB is set, retaining guard and sticky bits.
REQ-019 SHALL flush subnormal inputs to signed zero; subnormal outputs SHALL flush to signed zero with underflow=1 and inexact=1.
REQ-020 SHALL return canonical quiet NaN (sign 0, exponent all-ones, mantissa MSB 1, rest 0) with invalid=1 for any NaN operand or inf*0.
REQ-021 SHALL return signed infinity, flags 0, for inf*finite-nonzero or inf*inf.
REQ-022 SHALL return signed infinity with overflow=1, inexact=1 when the final exponent is >= all-ones, including a carry out of rounding.
REQ-023 SHALL set inexact when any discarded product bit is 1.

Reset
REQ-024 SHALL clear all stage valid bits, out_valid, result and flags to 0 in the cycle rst is sampled high; in-flight operations are discarded.
REQ-025 SHALL drive in_ready=1 in the first cycle after reset is released.

Configuration
REQ-026 SHALL, with FP_MUL_RNE_EN defined, round to nearest, ties to even, using guard/round/sticky bits.
REQ-027 SHALL, without FP_MUL_RNE_EN, truncate toward zero; inexact is still reported; latency is unchanged.

Structure
REQ-028 SHALL place in shared package fp_pkg: the default EXP_W/MAN_W constants, the bias function, the canonical-NaN constant, the operand-class enum (ZERO, NORMAL, INF, NAN) and the flag bit indices.
REQ-029 SHALL implement S3 as sub-module fp_round_pack (mantissa+GRS in; rounded, packed word and inexact/overflow out).

Verification
REQ-030 SHALL cover: a=0x40000000, b=0x40400000 -> result 0x40C00000, flags 0, out_valid exactly 3 cycles after accept.
REQ-031 SHALL cover: a=0x3F800001, b=0x3FC00000 -> 0x3FC00002 with FP_MUL_RNE_EN, 0x3FC00001 without; inexact=1 in both.
REQ-032 SHALL cover: a=0x7F800000, b=0x00000000 -> 0x7FC00000, invalid=1; a=0xFF800000, b=0x40000000 -> 0xFF800000, flags 0.
REQ-033 SHALL cover: a=0x7F7FFFFF, b=0x40000000 -> 0x7F800000 with overflow=1, inexact=1; a=0x00800000, b=0x3F000000 -> 0x00000000 with underflow=1.
REQ-034 SHALL cover: 4 back-to-back inputs with out_ready held low for 6 cycles -> in_ready drops once the pipeline is full, no result is lost or duplicated, and results appear in order once out_ready rises.
REQ-035 SHALL cover: rst asserted for 1 cycle with 2 operations in flight -> out_valid=0 on the next cycle, neither result ever appears, and in_ready=1 after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// default format widths, exponent bias, canonical quiet NaN,
// operand classes and flag bit positions.
package fp_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;

    // Canonical quiet NaN for the default 32-bit format
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}
    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_e;

    // Exponent bias for an exponent field of exp_w bits
    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final stage of the multiplier: rounds a normalised fraction with its
// guard/round/sticky bits and packs sign/exponent/fraction into a word.
// Rounding mode: FP_MUL_RNE_EN defined -> round to nearest, ties to even;
// undefined -> truncate toward zero.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                     i_sign,
    input  logic signed [EXP_W+1:0]  i_exp,
    input  logic [MAN_W-1:0]         i_frac,
    input  logic                     i_guard,
    input  logic                     i_round,
    input  logic                     i_sticky,
    output logic [EXP_W+MAN_W:0]     o_word,
    output logic                     o_inexact,
    output logic                     o_overflow
);

    localparam int XW = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    // Infinity with the given sign, used when the exponent saturates
    function automatic logic [EXP_W+MAN_W:0] inf_word(input logic sign);
        return {sign, EXP_ONES, {MAN_W{1'b0}}};
    endfunction

    logic                 w_up;
    logic [MAN_W:0]       w_frac_r;
    logic signed [XW-1:0] w_exp_f;

    // Round increment decision for the selected rounding mode
    always_comb begin
`ifdef FP_MUL_RNE_EN
        w_up = i_guard & (i_round | i_sticky | i_frac[0]);
`else
        w_up = 1'b0;
`endif
    end

    // Apply the increment; a carry out of the fraction means 1.111.. rolled
    // over to 10.000.., so the exponent steps up and the fraction is zero.
    always_comb begin
        w_frac_r   = {1'b0, i_frac} + {{MAN_W{1'b0}}, w_up};
        w_exp_f    = i_exp + $signed({{(XW-1){1'b0}}, w_frac_r[MAN_W]});
        o_overflow = (w_exp_f >= $signed({2'b00, EXP_ONES}));
        o_inexact  = i_guard | i_round | i_sticky | o_overflow;
        if (o_overflow) begin
            o_word = inf_word(i_sign);
        end else begin
            o_word = {i_sign, w_exp_f[EXP_W-1:0], w_frac_r[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 style multiplier with a global stall.
//   stage 1: unpack, classify, mantissa product, exponent sum
//   stage 2: normalise, guard/round/sticky extraction, underflow flush
//   stage 3: round and pack (fp_round_pack), special-case selection
// Optional macro FP_MUL_RNE_EN selects round-to-nearest-even; without it
// results are truncated toward zero with the same latency.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS_X   = XW'(fp_bias(EXP_W));
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // Subnormals (exponent 0) are treated as zero
    function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                           input logic [MAN_W-1:0] f);
        if (e == '0) begin
            return ZERO;
        end else if (e == EXP_ONES) begin
            if (f == '0) return INF;
            else         return NAN;
        end else begin
            return NORMAL;
        end
    endfunction

    logic                 w_adv;
    logic [EXP_W-1:0]     w_a_exp, w_b_exp;
    logic [MAN_W-1:0]     w_a_frac, w_b_frac;
    fp_class_e            w_a_cls, w_b_cls, w_cls_s1;
    logic [PW-1:0]        w_prod;
    logic signed [XW-1:0] w_esum;

    logic                 r_vld_p1, r_vld_p2, r_vld_p3;

    logic                 r_sign_p1;
    fp_class_e            r_cls_p1;
    logic [PW-1:0]        r_prod_p1;
    logic signed [XW-1:0] r_exp_p1;

    logic                 w_msb;
    logic [MAN_W-1:0]     w_frac_s2;
    logic                 w_g_s2, w_r_s2, w_s_s2;
    logic signed [XW-1:0] w_exp_s2;
    logic                 w_uf_s2;
    fp_class_e            w_cls_s2;

    logic                 r_sign_p2;
    fp_class_e            r_cls_p2;
    logic                 r_uf_p2;
    logic signed [XW-1:0] r_exp_p2;
    logic [MAN_W-1:0]     r_frac_p2;
    logic                 r_g_p2, r_r_p2, r_s_p2;

    logic [W-1:0]         w_rp_word;
    logic                 w_rp_inexact, w_rp_overflow;
    logic [W-1:0]         w_res_s3;
    logic [3:0]           w_flags_s3;

    logic [W-1:0]         r_result_p3;
    logic [3:0]           r_flags_p3;

    assign w_adv     = !r_vld_p3 || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld_p3;
    assign result    = r_result_p3;
    assign flags     = r_flags_p3;

    // Stage 1 datapath: field split, classification, product and exponent sum
    always_comb begin
        w_a_exp  = a[W-2:MAN_W];
        w_b_exp  = b[W-2:MAN_W];
        w_a_frac = a[MAN_W-1:0];
        w_b_frac = b[MAN_W-1:0];
        w_a_cls  = classify(w_a_exp, w_a_frac);
        w_b_cls  = classify(w_b_exp, w_b_frac);
        w_prod   = {{(MAN_W+1){1'b0}}, 1'b1, w_a_frac} * {{(MAN_W+1){1'b0}}, 1'b1, w_b_frac};
        w_esum   = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - BIAS_X;
        w_cls_s1 = NORMAL;
        if (w_a_cls == NAN || w_b_cls == NAN ||
            (w_a_cls == INF && w_b_cls == ZERO) ||
            (w_a_cls == ZERO && w_b_cls == INF)) begin
            w_cls_s1 = NAN;
        end else if (w_a_cls == INF || w_b_cls == INF) begin
            w_cls_s1 = INF;
        end else if (w_a_cls == ZERO || w_b_cls == ZERO) begin
            w_cls_s1 = ZERO;
        end
    end

    // Valid bits move with the global advance; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1 <= in_valid;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
        end
    end

    // ---- stage 1 / stage 2 boundary ----
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_sign_p1 <= a[W-1] ^ b[W-1];
            r_cls_p1  <= w_cls_s1;
            r_prod_p1 <= w_prod;
            r_exp_p1  <= w_esum;
        end
    end

    // Stage 2 datapath: product in [1,4); shift right once when it is >= 2
    always_comb begin
        w_msb = r_prod_p1[PW-1];
        if (w_msb) begin
            w_frac_s2 = r_prod_p1[PW-2:MAN_W+1];
            w_g_s2    = r_prod_p1[MAN_W];
            w_r_s2    = r_prod_p1[MAN_W-1];
            w_s_s2    = |r_prod_p1[MAN_W-2:0];
        end else begin
            w_frac_s2 = r_prod_p1[PW-3:MAN_W];
            w_g_s2    = r_prod_p1[MAN_W-1];
            w_r_s2    = r_prod_p1[MAN_W-2];
            w_s_s2    = |r_prod_p1[MAN_W-3:0];
        end
        w_exp_s2 = r_exp_p1 + $signed({{(XW-1){1'b0}}, w_msb});
        w_uf_s2  = (r_cls_p1 == NORMAL) && (w_exp_s2[XW-1] || (w_exp_s2 == '0));
        w_cls_s2 = w_uf_s2 ? ZERO : r_cls_p1;
    end

    // ---- stage 2 / stage 3 boundary ----
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_sign_p2 <= r_sign_p1;
            r_cls_p2  <= w_cls_s2;
            r_uf_p2   <= w_uf_s2;
            r_exp_p2  <= w_exp_s2;
            r_frac_p2 <= w_frac_s2;
            r_g_p2    <= w_g_s2;
            r_r_p2    <= w_r_s2;
            r_s_p2    <= w_s_s2;
        end
    end

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .i_sign     (r_sign_p2),
        .i_exp      (r_exp_p2),
        .i_frac     (r_frac_p2),
        .i_guard    (r_g_p2),
        .i_round    (r_r_p2),
        .i_sticky   (r_s_p2),
        .o_word     (w_rp_word),
        .o_inexact  (w_rp_inexact),
        .o_overflow (w_rp_overflow)
    );

    // Stage 3 selection: special classes override the rounded word
    always_comb begin
        w_res_s3   = w_rp_word;
        w_flags_s3 = 4'b0000;
        case (r_cls_p2)
            NAN: begin
                w_res_s3                 = QNAN;
                w_flags_s3[FLAG_INVALID] = 1'b1;
            end
            INF: begin
                w_res_s3 = {r_sign_p2, EXP_ONES, {MAN_W{1'b0}}};
            end
            ZERO: begin
                w_res_s3                   = {r_sign_p2, {(W-1){1'b0}}};
                w_flags_s3[FLAG_UNDERFLOW] = r_uf_p2;
                w_flags_s3[FLAG_INEXACT]   = r_uf_p2;
            end
            default: begin
                w_res_s3                  = w_rp_word;
                w_flags_s3[FLAG_OVERFLOW] = w_rp_overflow;
                w_flags_s3[FLAG_INEXACT]  = w_rp_inexact;
            end
        endcase
    end

    // ---- stage 3 / output boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result_p3 <= '0;
            r_flags_p3  <= '0;
        end else if (w_adv) begin
            r_result_p3 <= w_res_s3;
            r_flags_p3  <= w_flags_s3;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe (32-bit format) with a result scoreboard.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Present one operand pair, wait (bounded) for acceptance, record expectation
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [31:0] er, input logic [3:0] ef);
        int g;
        exp_t e;
        g = 0;
        a = ta;
        b = tb_;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        if (in_ready) begin
            e.res = er;
            e.flg = ef;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every result transfer must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_result observed=%h expected=none", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("flags", {28'd0, flags}, {28'd0, e.flg});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] st_a [4];
        logic [31:0] st_b [4];
        logic [31:0] st_r [4];
        int k;
        exp_t e;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 2*3 = 6 with exact 3-cycle latency
        send(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000);
        @(negedge clk);
        chk("lat_c1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_c2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_c3", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        drain();

        // back-to-back directed cases
`ifdef FP_MUL_RNE_EN
        send(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 4'b0001);
`else
        send(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0001, 4'b0001);
`endif
        send(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000);
        send(32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b1000);
        send(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000);
        send(32'h7F80_0000, 32'hFF80_0000, 32'hFF80_0000, 4'b0000);
        send(32'hFFFF_FFFF, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000);
        send(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 4'b0101);
        send(32'hFF7F_FFFF, 32'h4000_0000, 32'hFF80_0000, 4'b0101);
        send(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'b0011);
        send(32'h8080_0000, 32'h3F00_0000, 32'h8000_0000, 4'b0011);
        send(32'h0000_0000, 32'hC040_0000, 32'h8000_0000, 4'b0000);
        send(32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 4'b0000);
        send(32'h3F7F_FFFF, 32'h3F80_0001, 32'h3F80_0000, 4'b0001);
        send(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000);
        drain();

        // stall: 4 back-to-back with out_ready low for 6 cycles
        st_a[0] = 32'h4000_0000; st_b[0] = 32'h4040_0000; st_r[0] = 32'h40C0_0000;
        st_a[1] = 32'h3FC0_0000; st_b[1] = 32'h3FC0_0000; st_r[1] = 32'h4010_0000;
        st_a[2] = 32'hC000_0000; st_b[2] = 32'h3F00_0000; st_r[2] = 32'hBF80_0000;
        st_a[3] = 32'h4080_0000; st_b[3] = 32'h4080_0000; st_r[3] = 32'h4180_0000;
        out_ready = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            a = st_a[k];
            b = st_b[k];
            in_valid = 1'b1;
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, (cyc < 3) ? 32'd1 : 32'd0);
            if (cyc >= 3) begin
                chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_hold_result", result, st_r[0]);
            end
            if (in_ready) begin
                e.res = st_r[k];
                e.flg = 4'b0000;
                sb.push_back(e);
                k++;
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(st_a[3], st_b[3], st_r[3], 4'b0000);
        drain();

        // reset with two operations in flight
        send(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 4'b0000);
        send(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 4'b0000);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush_no_result", {31'd0, out_valid}, 32'd0);
        end
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
